vga_timing_gen: RTL

//  Raster timing source for the display pipeline: drives DrawX/DrawY, blank (1 = visible)
//  and active-low hsync/vsync consumed by the background/sprite renderers and the VGA/HDMI

---
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with aligned sync, blank and strobe outputs.
// Every output is registered and is decoded from the position that is loaded on the same edge.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL < 1 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must lie in 1..1024");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [9:0]  x_s;
  logic [9:0]  y_s;
  logic        advance_s;
  logic        hsync_s;
  logic        vsync_s;
  logic        blank_s;
  logic        line_start_s;
  logic        frame_start_s;
  logic [15:0] frame_count_s;

  // Half-open window test [lo, hi) on a counter value.
  function automatic logic in_window(input logic [9:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

  // State register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, next position and the outputs decoded from that position.
  always_comb begin
    state_s       = state_r;
    x_s           = DrawX;
    y_s           = DrawY;
    advance_s     = 1'b0;
    frame_count_s = frame_count;
    hsync_s       = hsync;
    vsync_s       = vsync;
    blank_s       = blank;
    line_start_s  = 1'b0;
    frame_start_s = 1'b0;

    case (state_r)
      IDLE: begin
        state_s   = RUN;
        x_s       = 10'd0;
        y_s       = 10'd0;
        advance_s = 1'b1;
      end
      RUN: begin
        if (ce) begin
          advance_s = 1'b1;
          if (DrawX == H_LAST) begin
            x_s = 10'd0;
            if (DrawY == V_LAST) begin
              y_s           = 10'd0;
              frame_count_s = frame_count + 16'd1;
            end else begin
              y_s = DrawY + 10'd1;
            end
          end else begin
            x_s = DrawX + 10'd1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Held clocks keep sync/blank but never repeat a strobe.
    if (advance_s) begin
      hsync_s       = !in_window(x_s, HS_START, HS_STOP);
      vsync_s       = !in_window(y_s, VS_START, VS_STOP);
      blank_s       = in_window(x_s, 0, H_ACTIVE) && in_window(y_s, 0, V_ACTIVE);
      line_start_s  = (x_s == 10'd0);
      frame_start_s = (x_s == 10'd0) && (y_s == 10'd0);
    end else begin
      line_start_s  = 1'b0;
      frame_start_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      DrawX       <= x_s;
      DrawY       <= y_s;
      hsync       <= hsync_s;
      vsync       <= vsync_s;
      blank       <= blank_s;
      line_start  <= line_start_s;
      frame_start <= frame_start_s;
      frame_count <= frame_count_s;
    end
  end

endmodule
